// File: rtl/rep3_pkg.sv
// Shared definitions for the triple-repetition serial link (transmit and receive sides).
package rep3_pkg;

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  localparam int REP_COUNT = 3;

  // Bits needed for a counter running 0..n-1, never less than one.
  function automatic int ctr_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rep3_sym_timer.sv
// Symbol-hold and repetition counters for rep3_serial_tx.
// sym_last marks the final clock of a symbol; rep_last marks the final repetition of a bit.
module rep3_sym_timer
  import rep3_pkg::*;
#(
  parameter int CLKS_PER_SYM = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic sym_last,
  output logic rep_last
);

  localparam int SYM_W = ctr_w(CLKS_PER_SYM);
  localparam int REP_W = ctr_w(REP_COUNT);

  logic [SYM_W-1:0] sym_cnt_q, sym_cnt_d;
  logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;

  assign sym_last = (sym_cnt_q == SYM_W'(CLKS_PER_SYM - 1));
  assign rep_last = (rep_cnt_q == REP_W'(REP_COUNT - 1));

  always_comb begin
    sym_cnt_d = sym_cnt_q;
    rep_cnt_d = rep_cnt_q;
    if (clr) begin
      sym_cnt_d = '0;
      rep_cnt_d = '0;
    end else if (en) begin
      // Both counters wrap at their terminal value, so they sit at zero between frames.
      if (sym_last) begin
        sym_cnt_d = '0;
        rep_cnt_d = rep_last ? '0 : rep_cnt_q + REP_W'(1);
      end else begin
        sym_cnt_d = sym_cnt_q + SYM_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sym_cnt_q <= '0;
      rep_cnt_q <= '0;
    end else begin
      sym_cnt_q <= sym_cnt_d;
      rep_cnt_q <= rep_cnt_d;
    end
  end

endmodule

// File: rtl/rep3_serial_tx.sv
// Triple-repetition serial transmitter: word in over valid/ready, each bit sent MSB first three times.
// Defining REP3_TX_PARITY_EN appends a triple-repeated even-parity bit after the data bits.
module rep3_serial_tx
  import rep3_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_SYM = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              tx_sym,
  output logic              tx_frame,
  output logic              tx_first,
  output logic              done
);

`ifdef REP3_TX_PARITY_EN
  localparam int NBITS = DATA_W + 1;
`else
  localparam int NBITS = DATA_W;
`endif
  localparam int BIT_W = ctr_w(NBITS);

  state_t           state_q, state_d;
  logic [NBITS-1:0] shift_q, shift_d, shift_nx, load_w;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             in_ready_q, in_ready_d;
  logic             tx_sym_q, tx_sym_d;
  logic             tx_frame_q, tx_frame_d;
  logic             tx_first_q, tx_first_d;
  logic             done_q, done_d;
  logic             accept, sym_last, rep_last, bit_last;

`ifdef REP3_TX_PARITY_EN
  assign load_w = {in_data, ^in_data};
`else
  assign load_w = in_data;
`endif

  assign accept   = (state_q == IDLE) && in_valid && in_ready_q;
  assign bit_last = (bit_cnt_q == BIT_W'(NBITS - 1));
  assign shift_nx = shift_q << 1;

  rep3_sym_timer #(.CLKS_PER_SYM(CLKS_PER_SYM)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clr      (accept),
    .en       (state_q == SEND),
    .sym_last (sym_last),
    .rep_last (rep_last)
  );

  // Outputs are computed from the next state so the first symbol appears the cycle after acceptance.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    in_ready_d = in_ready_q;
    tx_sym_d   = tx_sym_q;
    tx_frame_d = tx_frame_q;
    tx_first_d = tx_first_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready_d = 1'b1;
        tx_sym_d   = 1'b0;
        tx_frame_d = 1'b0;
        tx_first_d = 1'b0;
        if (accept) begin
          state_d    = SEND;
          shift_d    = load_w;
          bit_cnt_d  = '0;
          in_ready_d = 1'b0;
          tx_sym_d   = load_w[NBITS-1];
          tx_frame_d = 1'b1;
          tx_first_d = 1'b1;
        end
      end
      SEND: begin
        in_ready_d = 1'b0;
        if (sym_last) tx_first_d = 1'b0;
        if (sym_last && rep_last) begin
          if (bit_last) begin
            state_d    = DONE;
            bit_cnt_d  = '0;
            tx_sym_d   = 1'b0;
            tx_frame_d = 1'b0;
            done_d     = 1'b1;
          end else begin
            shift_d   = shift_nx;
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
            tx_sym_d  = shift_nx[NBITS-1];
          end
        end
      end
      DONE: begin
        state_d    = IDLE;
        in_ready_d = 1'b1;
        tx_sym_d   = 1'b0;
        tx_frame_d = 1'b0;
        tx_first_d = 1'b0;
      end
      default: begin
        state_d    = IDLE;
        in_ready_d = 1'b0;
        tx_sym_d   = 1'b0;
        tx_frame_d = 1'b0;
        tx_first_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      in_ready_q <= 1'b0;
      tx_sym_q   <= 1'b0;
      tx_frame_q <= 1'b0;
      tx_first_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      in_ready_q <= in_ready_d;
      tx_sym_q   <= tx_sym_d;
      tx_frame_q <= tx_frame_d;
      tx_first_q <= tx_first_d;
      done_q     <= done_d;
    end
  end

  assign in_ready = in_ready_q;
  assign tx_sym   = tx_sym_q;
  assign tx_frame = tx_frame_q;
  assign tx_first = tx_first_q;
  assign done     = done_q;

endmodule
